// File: rtl/move_validator.sv
// move_validator: walks one direction from a candidate empty cell on a bordered 10x10
// board and reports whether the move would capture at least one opponent disc.
//
// Optional feature: define VALI_FLIP_EN to add a FLIP state that writes the player
// colour over the captured discs (ports flip_in, mem_we_o, mem_wdata_o).
//
// Ports:
//   clock        - single clock, rising edge
//   reset        - asynchronous active-low reset
//   enable       - start one direction walk (honoured only while idle)
//   ld           - capture step_in/origin_in/player_in (and flip_in) while idle
//   step_in      - signed cell step (-10, 10, -1, 1)
//   origin_in    - candidate empty cell address
//   player_in    - moving colour (01 black, 10 white)
//   mem_addr_o   - board RAM address
//   mem_rd_o     - board RAM read strobe, data returns one cycle later
//   mem_data_i   - cell value (00 empty, 01 black, 10 white, 11 border)
//   s_done_o     - one-cycle walk-complete pulse
//   dir_status_o - 1 when the direction captures, held until the next start
module move_validator #(
  parameter int unsigned ROW_W   = 10,
  parameter int unsigned MAX_RUN = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       ld,
  input  logic [4:0] step_in,
  input  logic [6:0] origin_in,
  input  logic [1:0] player_in,
`ifdef VALI_FLIP_EN
  input  logic       flip_in,
  output logic       mem_we_o,
  output logic [1:0] mem_wdata_o,
`endif
  output logic [6:0] mem_addr_o,
  output logic       mem_rd_o,
  input  logic [1:0] mem_data_i,
  output logic       s_done_o,
  output logic       dir_status_o
);

  localparam int unsigned RunW     = $clog2(MAX_RUN + 1);
  localparam logic [7:0]  LastCell = 8'(ROW_W * ROW_W - 1);

`ifdef VALI_FLIP_EN
  typedef enum logic [2:0] {StIdle, StRead, StCheck, StFlip, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRead, StCheck, StDone} state_e;
`endif

  state_e             state_q;
  logic [4:0]         step_q;
  logic [6:0]         origin_q;
  logic [1:0]         player_q;
  logic signed [7:0]  cur_q;
  logic [RunW-1:0]    run_q;
  logic [6:0]         mem_addr_q;
  logic               mem_rd_q;
  logic               s_done_q;
  logic               dir_q;
`ifdef VALI_FLIP_EN
  logic               flip_q;
  logic               we_q;
  logic [RunW-1:0]    wcnt_q;
  logic signed [7:0]  flip_start;
`endif

  // A same-cycle ld/enable walks with the values presented that cycle.
  logic [4:0]        step_sel;
  logic [6:0]        origin_sel;
  logic signed [7:0] start_cur;
  logic signed [7:0] step_ext;
  logic signed [7:0] next_cur;
  logic [RunW-1:0]   run_inc;
  logic [1:0]        opp_colour;
  logic              is_colour;

  assign step_sel   = ld ? step_in : step_q;
  assign origin_sel = ld ? origin_in : origin_q;
  assign start_cur  = $signed({1'b0, origin_sel}) + $signed({{3{step_sel[4]}}, step_sel});
  assign step_ext   = $signed({{3{step_q[4]}}, step_q});
  assign next_cur   = cur_q + step_ext;
  assign run_inc    = run_q + RunW'(1);
  assign opp_colour = {player_q[0], player_q[1]};
  // Only 01/10 are disc colours; empty and border never match a player.
  assign is_colour  = ^mem_data_i;
`ifdef VALI_FLIP_EN
  assign flip_start = $signed({1'b0, origin_q}) + step_ext;
`endif

  function automatic logic in_range(input logic signed [7:0] c);
    return !c[7] && ($unsigned(c) <= LastCell);
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      step_q     <= '0;
      origin_q   <= '0;
      player_q   <= '0;
      cur_q      <= '0;
      run_q      <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      s_done_q   <= 1'b0;
      dir_q      <= 1'b0;
`ifdef VALI_FLIP_EN
      flip_q     <= 1'b0;
      we_q       <= 1'b0;
      wcnt_q     <= '0;
`endif
    end else begin
      s_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ld) begin
            step_q   <= step_in;
            origin_q <= origin_in;
            player_q <= player_in;
`ifdef VALI_FLIP_EN
            flip_q   <= flip_in;
`endif
          end
          if (enable) begin
            state_q    <= StRead;
            dir_q      <= 1'b0;
            run_q      <= '0;
            cur_q      <= start_cur;
            mem_addr_q <= start_cur[6:0];
            // Off-board address: no read is issued and READ exits straight to DONE.
            mem_rd_q   <= in_range(start_cur);
          end
        end
        StRead: begin
          mem_rd_q <= 1'b0;
          if (mem_rd_q) begin
            state_q <= StCheck;
          end else begin
            state_q  <= StDone;
            s_done_q <= 1'b1;
          end
        end
        StCheck: begin
          if (is_colour && (mem_data_i == opp_colour)) begin
            if (run_inc == RunW'(MAX_RUN)) begin
              state_q  <= StDone;
              s_done_q <= 1'b1;
            end else begin
              run_q      <= run_inc;
              cur_q      <= next_cur;
              mem_addr_q <= next_cur[6:0];
              mem_rd_q   <= in_range(next_cur);
              state_q    <= StRead;
            end
          end else if (is_colour && (mem_data_i == player_q) && (run_q != '0)) begin
`ifdef VALI_FLIP_EN
            if (flip_q) begin
              state_q    <= StFlip;
              cur_q      <= flip_start;
              mem_addr_q <= flip_start[6:0];
              we_q       <= 1'b1;
              wcnt_q     <= RunW'(1);
            end else begin
              state_q  <= StDone;
              s_done_q <= 1'b1;
              dir_q    <= 1'b1;
            end
`else
            state_q  <= StDone;
            s_done_q <= 1'b1;
            dir_q    <= 1'b1;
`endif
          end else begin
            state_q  <= StDone;
            s_done_q <= 1'b1;
          end
        end
`ifdef VALI_FLIP_EN
        // One captured cell written per cycle, nearest to the origin first.
        StFlip: begin
          if (wcnt_q == run_q) begin
            we_q     <= 1'b0;
            state_q  <= StDone;
            s_done_q <= 1'b1;
            dir_q    <= 1'b1;
          end else begin
            cur_q      <= next_cur;
            mem_addr_q <= next_cur[6:0];
            wcnt_q     <= wcnt_q + RunW'(1);
          end
        end
`endif
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mem_addr_o   = mem_addr_q;
  assign mem_rd_o     = mem_rd_q;
  assign s_done_o     = s_done_q;
  assign dir_status_o = dir_q;
`ifdef VALI_FLIP_EN
  assign mem_we_o     = we_q;
  assign mem_wdata_o  = we_q ? player_q : 2'b00;
`endif

endmodule

// File: tb/tb_move_validator.sv
// Scoreboard bench for move_validator: the driver pushes the expected latency, status
// and read count per walk; a negedge monitor pops and compares on every s_done_o.
module tb_move_validator;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       ld;
  logic [4:0] step_in;
  logic [6:0] origin_in;
  logic [1:0] player_in;
  logic [6:0] mem_addr_o;
  logic       mem_rd_o;
  logic [1:0] mem_data_i;
  logic       s_done_o;
  logic       dir_status_o;
`ifdef VALI_FLIP_EN
  logic       flip_in;
  logic       mem_we_o;
  logic [1:0] mem_wdata_o;
`endif

  localparam logic [4:0] StpP1  = 5'b00001;
  localparam logic [4:0] StpM1  = 5'b11111;
  localparam logic [4:0] StpP10 = 5'b01010;
  localparam logic [4:0] StpM10 = 5'b10110;

  move_validator #(.ROW_W(10), .MAX_RUN(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .ld           (ld),
    .step_in      (step_in),
    .origin_in    (origin_in),
    .player_in    (player_in),
`ifdef VALI_FLIP_EN
    .flip_in      (flip_in),
    .mem_we_o     (mem_we_o),
    .mem_wdata_o  (mem_wdata_o),
`endif
    .mem_addr_o   (mem_addr_o),
    .mem_rd_o     (mem_rd_o),
    .mem_data_i   (mem_data_i),
    .s_done_o     (s_done_o),
    .dir_status_o (dir_status_o)
  );

  always #5 clock = ~clock;

  // Board RAM model: one-cycle read latency.
  logic [1:0] board [0:127];
  always @(posedge clock) begin
    if (mem_rd_o) mem_data_i <= board[mem_addr_o];
  end

  typedef struct packed {
    int lat;
    int stat;
    int reads;
  } exp_t;

  exp_t       sb_q[$];
  logic [8:0] wr_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         t0 = 0;
  int         rd_cnt = 0;
  int         done_cnt = 0;
  bit         busy = 1'b0;
  bit         chk_clear = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: detects starts, counts reads, checks each completion against the scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      busy      = 1'b0;
      chk_clear = 1'b0;
    end else begin
      if (chk_clear) begin
        chk("dir_clear_on_start", dir_status_o, 0);
        chk_clear = 1'b0;
      end
      if (busy && mem_rd_o) rd_cnt++;
`ifdef VALI_FLIP_EN
      if (mem_we_o) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", {mem_addr_o, mem_wdata_o}, 0);
        end else begin
          logic [8:0] w;
          w = wr_q.pop_front();
          chk("flip_write", {mem_addr_o, mem_wdata_o}, w);
        end
      end
`endif
      if (s_done_o) begin
        if (sb_q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("latency", cyc - t0, e.lat);
          chk("dir_status", dir_status_o, e.stat);
          chk("read_count", rd_cnt, e.reads);
        end
        busy = 1'b0;
        done_cnt++;
      end
      if (enable && !busy) begin
        busy      = 1'b1;
        t0        = cyc;
        rd_cnt    = 0;
        chk_clear = 1'b1;
      end
    end
  end

  task automatic clear_board();
    for (int i = 0; i < 128; i++) begin
      if (i >= 100 || i < 10 || i >= 90 || (i % 10) == 0 || (i % 10) == 9) board[i] = 2'b11;
      else board[i] = 2'b00;
    end
  endtask

  // Expected result; in the flip build a capturing walk adds one write per captured disc.
  task automatic push_exp(input int lat, input int stat, input int reads, input int run,
                          input logic [6:0] org, input logic [4:0] stp, input logic [1:0] ply);
    exp_t e;
    e.lat   = lat;
    e.stat  = stat;
    e.reads = reads;
`ifdef VALI_FLIP_EN
    if (stat != 0) begin
      e.lat = lat + run;
      for (int k = 1; k <= run; k++) begin
        logic [31:0] a;
        a = 32'(org) + 32'(k) * {{27{stp[4]}}, stp};
        wr_q.push_back({a[6:0], ply});
      end
    end
`else
    if (run < 0) e.lat = 0;
`endif
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input int n0, input logic [1:0] held);
    for (int i = 0; i < 60 && done_cnt == n0; i++) @(posedge clock);
    chk("walk_completed", done_cnt > n0, 1);
    @(posedge clock); #1;
    chk("dir_hold", dir_status_o, held);
  endtask

  task automatic walk(input logic [6:0] org, input logic [4:0] stp, input logic [1:0] ply,
                      input int lat, input int stat, input int reads, input int run);
    int n0;
    push_exp(lat, stat, reads, run, org, stp, ply);
    n0 = done_cnt;
    @(posedge clock); #1;
    ld = 1'b1; enable = 1'b1; origin_in = org; step_in = stp; player_in = ply;
`ifdef VALI_FLIP_EN
    flip_in = 1'b1;
`endif
    @(posedge clock); #1;
    ld = 1'b0; enable = 1'b0;
    origin_in = 7'($urandom); step_in = 5'($urandom); player_in = 2'($urandom);
    wait_done(n0, 2'(stat));
  endtask

  initial begin
    int n0;
    reset = 1'b0; enable = 1'b0; ld = 1'b0;
    step_in = '0; origin_in = '0; player_in = '0;
`ifdef VALI_FLIP_EN
    flip_in = 1'b0;
`endif
    clear_board();
    repeat (3) @(posedge clock);
    #1;
    chk("reset_s_done", s_done_o, 0);
    chk("reset_dir_status", dir_status_o, 0);
    chk("reset_mem_rd", mem_rd_o, 0);
    chk("reset_mem_addr", mem_addr_o, 0);
    reset = 1'b1;

    // Capture after one opponent disc.
    board[45] = 2'b10; board[46] = 2'b01;
    walk(7'd44, StpP1, 2'b01, 5, 1, 2, 1);
    // Own colour with no run.
    board[34] = 2'b01;
    walk(7'd44, StpM10, 2'b01, 3, 0, 1, 0);
    walk(7'd44, StpP1, 2'b10, 3, 0, 1, 0);
    // Border immediately, then off-board addresses (no read).
    walk(7'd11, StpM10, 2'b01, 3, 0, 1, 0);
    walk(7'd5, StpM10, 2'b01, 2, 0, 0, 0);
    walk(7'd95, StpP10, 2'b01, 2, 0, 0, 0);
    // Empty neighbour.
    walk(7'd44, StpM1, 2'b01, 3, 0, 1, 0);

    // Seven opponent reads then the border at 49.
    clear_board();
    for (int c = 42; c <= 48; c++) board[c] = 2'b10;
    walk(7'd41, StpP1, 2'b01, 17, 0, 8, 0);
    // Eight opponents reach the run limit before any terminating cell is read.
    for (int c = 11; c <= 18; c++) board[c] = 2'b10;
    walk(7'd10, StpP1, 2'b01, 17, 0, 8, 0);

    // White capturing two black discs southwards, loaded a cycle before the start.
    clear_board();
    board[65] = 2'b01; board[75] = 2'b01; board[85] = 2'b10;
    push_exp(7, 1, 3, 2, 7'd55, StpP10, 2'b10);
    n0 = done_cnt;
    @(posedge clock); #1;
    ld = 1'b1; origin_in = 7'd55; step_in = StpP10; player_in = 2'b10;
`ifdef VALI_FLIP_EN
    flip_in = 1'b1;
`endif
    @(posedge clock); #1;
    ld = 1'b0; enable = 1'b1; origin_in = 7'd0; step_in = StpM1; player_in = 2'b01;
    @(posedge clock); #1;
    enable = 1'b0;
    // ld and enable while busy must be ignored.
    @(posedge clock); #1;
    ld = 1'b1; enable = 1'b1; origin_in = 7'd22; step_in = StpM10; player_in = 2'b01;
`ifdef VALI_FLIP_EN
    flip_in = 1'b0;
`endif
    @(posedge clock); #1;
    ld = 1'b0; enable = 1'b0;
    wait_done(n0, 2'b01);
    // Restart on the held capture registers only.
    push_exp(7, 1, 3, 2, 7'd55, StpP10, 2'b10);
    n0 = done_cnt;
    @(posedge clock); #1;
    enable = 1'b1;
    @(posedge clock); #1;
    enable = 1'b0;
    wait_done(n0, 2'b01);

    // Reset during the second READ of the capture walk.
    clear_board();
    board[45] = 2'b10; board[46] = 2'b01;
    @(posedge clock); #1;
    ld = 1'b1; enable = 1'b1; origin_in = 7'd44; step_in = StpP1; player_in = 2'b01;
    @(posedge clock); #1;
    ld = 1'b0; enable = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("second_read_active", mem_rd_o, 1);
    chk("second_read_addr", mem_addr_o, 46);
    reset = 1'b0;
    #1;
    chk("midwalk_reset_s_done", s_done_o, 0);
    chk("midwalk_reset_dir", dir_status_o, 0);
    chk("midwalk_reset_mem_rd", mem_rd_o, 0);
    chk("midwalk_reset_mem_addr", mem_addr_o, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    walk(7'd44, StpP1, 2'b01, 5, 1, 2, 1);

    repeat (3) @(posedge clock);
    chk("scoreboard_drained", sb_q.size(), 0);
    chk("writes_drained", wr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
